// File: rtl/gxsim_bank_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : gxsim_bank_access_arbiter_if
// Brief    : Requester handshakes plus the shared bank bus of the GenX
//            bank-access arbiter, bundled for port connection.
// Revision : 1.0 - initial release
// ============================================================================
interface gxsim_bank_access_arbiter_if #(
    parameter int NUM_BANKS = 4
);
    // Requester 0: QSPI command decoder
    logic                      r0_req;
    logic                      r0_write;
    logic [31:0]               r0_addr;
    logic [31:0]               r0_wdata;
    logic                      r0_ack;
    logic [31:0]               r0_rdata;
    logic                      r0_err;

    // Requester 1: host/debug port
    logic                      r1_req;
    logic                      r1_write;
    logic [31:0]               r1_addr;
    logic [31:0]               r1_wdata;
    logic                      r1_ack;
    logic [31:0]               r1_rdata;
    logic                      r1_err;

    // Shared bank bus
    logic [31:0]               bus_address;
    logic [31:0]               bus_wdata;
    logic                      bus_write_strobe;
    logic [NUM_BANKS-1:0]      bus_bank_select;
    logic [32*NUM_BANKS-1:0]   bus_rdata;

    // Environment side: the requesters and the bank instances
    modport master (
        output r0_req, r0_write, r0_addr, r0_wdata,
        input  r0_ack, r0_rdata, r0_err,
        output r1_req, r1_write, r1_addr, r1_wdata,
        input  r1_ack, r1_rdata, r1_err,
        input  bus_address, bus_wdata, bus_write_strobe, bus_bank_select,
        output bus_rdata
    );

    // Arbiter side
    modport slave (
        input  r0_req, r0_write, r0_addr, r0_wdata,
        output r0_ack, r0_rdata, r0_err,
        input  r1_req, r1_write, r1_addr, r1_wdata,
        output r1_ack, r1_rdata, r1_err,
        output bus_address, bus_wdata, bus_write_strobe, bus_bank_select,
        input  bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/gxsim_bank_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gxsim_bank_access_arbiter
// Brief    : Round-robin arbiter sharing the GenX bank-register/SMEM banks
//            between the QSPI decoder (requester 0) and the host/debug port
//            (requester 1). Each access runs IDLE -> SETUP -> ACCESS -> RESP.
// Revision : 1.0 - initial release
// ============================================================================
module gxsim_bank_access_arbiter #(
    parameter int          NUM_BANKS = 4,
    parameter int          BANK_LSB  = 20,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  wire logic                    clk,
    input  wire logic                    resetn,
    gxsim_bank_access_arbiter_if.slave   acc
);

    // Bank field width; a single bank has an empty field, so keep a 1-bit index
    localparam int          FIELD_W  = $clog2(NUM_BANKS);
    localparam int          IDX_W    = (FIELD_W > 0) ? FIELD_W : 1;
    localparam logic [31:0] IDX_MASK = 32'((64'd1 << FIELD_W) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;

    logic               req_any;
    logic               grant_next;
    logic               sel_write;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic [31:0]        addr_hi;
    logic [31:0]        idx_full;
    logic               dec_err;
    logic [IDX_W-1:0]   dec_idx;

    logic               grant;
    logic               last_grant;
    logic               lat_write;
    logic               lat_err;
    logic [IDX_W-1:0]   lat_idx;
    logic [31:0]        bus_address_q;
    logic [31:0]        bus_wdata_q;

    logic [NUM_BANKS-1:0] onehot;
    logic [NUM_BANKS-1:0] bank_select;
    logic               write_strobe;
    logic               r0_ack_c;
    logic               r1_ack_c;
    logic [31:0]        bank_rdata;
    logic [31:0]        resp_data;

    logic [31:0]        r0_rdata_q;
    logic               r0_err_q;
    logic [31:0]        r1_rdata_q;
    logic               r1_err_q;

    // Arbitration: a lone request wins, a tie goes to whoever was not granted last
    always_comb begin
        req_any    = acc.r0_req | acc.r1_req;
        grant_next = 1'b0;
        if (acc.r0_req && acc.r1_req) begin
            grant_next = ~last_grant;
        end else if (acc.r1_req) begin
            grant_next = 1'b1;
        end
        sel_write = grant_next ? acc.r1_write : acc.r0_write;
        sel_addr  = grant_next ? acc.r1_addr  : acc.r0_addr;
        sel_wdata = grant_next ? acc.r1_wdata : acc.r0_wdata;
    end

    // Bank decode: index field plus a check that nothing above it is set
    always_comb begin
        addr_hi  = sel_addr >> (BANK_LSB + FIELD_W);
        idx_full = (sel_addr >> BANK_LSB) & IDX_MASK;
        dec_err  = (addr_hi != 32'd0) || (idx_full >= 32'(NUM_BANKS));
        dec_idx  = idx_full[IDX_W-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus/handshake control decoded from the current state
    always_comb begin
        state_next   = state;
        bank_select  = '0;
        write_strobe = 1'b0;
        r0_ack_c     = 1'b0;
        r1_ack_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_any) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                bank_select = lat_err ? '0 : onehot;
                state_next  = ST_ACCESS;
            end
            ST_ACCESS: begin
                bank_select = lat_err ? '0 : onehot;
                // Gated by resetn so a reset landing here abandons the write cleanly
                write_strobe = lat_write && !lat_err && resetn;
                state_next   = ST_RESP;
            end
            ST_RESP: begin
                r0_ack_c   = ~grant;
                r1_ack_c   = grant;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // One-hot select and read-data mux for the latched bank index
    always_comb begin
        onehot     = '0;
        bank_rdata = 32'd0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (lat_idx == IDX_W'(k)) begin
                onehot[k]  = 1'b1;
                bank_rdata = acc.bus_rdata[32*k +: 32];
            end
        end
        if (lat_err) begin
            resp_data = ERR_RDATA;
        end else if (lat_write) begin
            resp_data = 32'd0;
        end else begin
            resp_data = bank_rdata;
        end
    end

    // Request latch in IDLE and response capture at the end of ACCESS
    always_ff @(posedge clk) begin
        if (!resetn) begin
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            lat_write     <= 1'b0;
            lat_err       <= 1'b0;
            lat_idx       <= '0;
            bus_address_q <= 32'd0;
            bus_wdata_q   <= 32'd0;
            r0_rdata_q    <= 32'd0;
            r0_err_q      <= 1'b0;
            r1_rdata_q    <= 32'd0;
            r1_err_q      <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_any) begin
                grant         <= grant_next;
                last_grant    <= grant_next;
                lat_write     <= sel_write;
                lat_err       <= dec_err;
                lat_idx       <= dec_idx;
                bus_address_q <= sel_addr;
                bus_wdata_q   <= sel_wdata;
            end
            if (state == ST_ACCESS) begin
                if (grant) begin
                    r1_rdata_q <= resp_data;
                    r1_err_q   <= lat_err;
                end else begin
                    r0_rdata_q <= resp_data;
                    r0_err_q   <= lat_err;
                end
            end
        end
    end

    assign acc.bus_address      = bus_address_q;
    assign acc.bus_wdata        = bus_wdata_q;
    assign acc.bus_bank_select  = bank_select;
    assign acc.bus_write_strobe = write_strobe;
    assign acc.r0_ack           = r0_ack_c;
    assign acc.r0_rdata         = r0_rdata_q;
    assign acc.r0_err           = r0_err_q;
    assign acc.r1_ack           = r1_ack_c;
    assign acc.r1_rdata         = r1_rdata_q;
    assign acc.r1_err           = r1_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gxsim_bank_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gxsim_bank_access_arbiter
// Brief    : Directed self-checking bench for gxsim_bank_access_arbiter with
//            four register-backed banks on the shared bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gxsim_bank_access_arbiter;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_mis;
    int   viol;

    logic [31:0] mem [4][16];

    gxsim_bank_access_arbiter_if #(.NUM_BANKS(4)) ifc ();

    gxsim_bank_access_arbiter #(
        .NUM_BANKS (4),
        .BANK_LSB  (20),
        .ERR_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .acc    (ifc)
    );

    // Free-running clock, 10 time units
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bank register models: reload a known pattern on reset, write on strobe
    always @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < 16; i++) begin
                    mem[k][i] <= 32'hB000_0000 | 32'(k << 8) | 32'(i);
                end
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (ifc.bus_write_strobe && ifc.bus_bank_select[k]) begin
                    mem[k][ifc.bus_address[5:2]] <= ifc.bus_wdata;
                end
            end
        end
    end

    // Combinational read data from every bank
    always_comb begin
        ifc.bus_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            ifc.bus_rdata[32*k +: 32] = mem[k][ifc.bus_address[5:2]];
        end
    end

    // Bus invariants sampled mid-cycle
    initial viol = 0;
    always @(negedge clk) begin
        if ($countones(ifc.bus_bank_select) > 1) viol++;
        if (ifc.bus_write_strobe && ifc.bus_bank_select == 4'b0000) viol++;
        if (ifc.r0_ack && ifc.r1_ack) viol++;
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int who, input bit req, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (who == 0) begin
            ifc.r0_req = req; ifc.r0_write = wr; ifc.r0_addr = addr; ifc.r0_wdata = wd;
        end else begin
            ifc.r1_req = req; ifc.r1_write = wr; ifc.r1_addr = addr; ifc.r1_wdata = wd;
        end
    endtask

    // One complete access from a single requester, checked cycle by cycle
    task automatic do_access(input string tag, input int who, input bit wr,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] exp_sel, input logic [31:0] exp_rd,
                             input bit exp_err);
        logic own_ack;
        logic oth_ack;
        drive(who, 1'b1, wr, addr, wd);
        tick();
        chk({tag, ".setup_sel"}, ifc.bus_bank_select, exp_sel);
        chk({tag, ".setup_strobe"}, ifc.bus_write_strobe, 1'b0);
        chk({tag, ".setup_addr"}, ifc.bus_address, addr);
        tick();
        chk({tag, ".access_sel"}, ifc.bus_bank_select, exp_sel);
        chk({tag, ".access_strobe"}, ifc.bus_write_strobe, wr && (exp_sel != 4'b0000));
        if (wr) chk({tag, ".access_wdata"}, ifc.bus_wdata, wd);
        tick();
        own_ack = (who == 0) ? ifc.r0_ack : ifc.r1_ack;
        oth_ack = (who == 0) ? ifc.r1_ack : ifc.r0_ack;
        chk({tag, ".resp_ack"}, own_ack, 1'b1);
        chk({tag, ".resp_other_ack"}, oth_ack, 1'b0);
        chk({tag, ".resp_sel"}, ifc.bus_bank_select, 4'b0000);
        chk({tag, ".resp_rdata"}, (who == 0) ? ifc.r0_rdata : ifc.r1_rdata, exp_rd);
        chk({tag, ".resp_err"}, (who == 0) ? ifc.r0_err : ifc.r1_err, exp_err);
        drive(who, 1'b0, wr, addr, wd);
        tick();
        own_ack = (who == 0) ? ifc.r0_ack : ifc.r1_ack;
        chk({tag, ".idle_ack"}, own_ack, 1'b0);
    endtask

    initial begin
        n_cmp  = 0;
        n_mis  = 0;
        resetn = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // Reset state
        chk("rst.r0_ack", ifc.r0_ack, 1'b0);
        chk("rst.r1_ack", ifc.r1_ack, 1'b0);
        chk("rst.bus_address", ifc.bus_address, 32'd0);
        chk("rst.bus_wdata", ifc.bus_wdata, 32'd0);
        chk("rst.sel", ifc.bus_bank_select, 4'b0000);
        chk("rst.strobe", ifc.bus_write_strobe, 1'b0);
        chk("rst.r0_rdata", ifc.r0_rdata, 32'd0);
        chk("rst.r1_err", ifc.r1_err, 1'b0);

        // Continuous dual reads: r0, r1, r0, r1 with acks 4 cycles apart
        drive(0, 1'b1, 1'b0, 32'h0000_0004, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h0030_000C, 32'd0);
        for (int c = 1; c <= 15; c++) begin
            tick();
            chk($sformatf("dual.r0_ack.c%0d", c), ifc.r0_ack, (c == 3 || c == 11));
            chk($sformatf("dual.r1_ack.c%0d", c), ifc.r1_ack, (c == 7 || c == 15));
            if (c == 3 || c == 11) chk($sformatf("dual.r0_rdata.c%0d", c), ifc.r0_rdata, 32'hB000_0001);
            if (c == 7 || c == 15) chk($sformatf("dual.r1_rdata.c%0d", c), ifc.r1_rdata, 32'hB000_0303);
            if (c == 15) begin
                ifc.r0_req = 1'b0;
                ifc.r1_req = 1'b0;
            end
        end
        tick();

        // Single write then read back through bank 1
        do_access("wr1", 0, 1'b1, 32'h0010_0010, 32'h1234_5678, 4'b0010, 32'd0, 1'b0);
        chk("wr1.mem", mem[1][4], 32'h1234_5678);
        do_access("rd1", 0, 1'b0, 32'h0010_0010, 32'd0, 4'b0010, 32'h1234_5678, 1'b0);

        // Decode error from r1; r0's response registers hold
        do_access("derr", 1, 1'b0, 32'h0050_0000, 32'd0, 4'b0000, 32'hDEAD_BEEF, 1'b1);
        chk("derr.r0_rdata_hold", ifc.r0_rdata, 32'h1234_5678);
        chk("derr.r0_err_hold", ifc.r0_err, 1'b0);

        // Bank isolation: a bank 2 write leaves the other banks alone
        do_access("iso.rd0a", 0, 1'b0, 32'h0000_0008, 32'd0, 4'b0001, 32'hB000_0002, 1'b0);
        do_access("iso.wr2", 0, 1'b1, 32'h0020_0008, 32'hAAAA_5555, 4'b0100, 32'd0, 1'b0);
        do_access("iso.rd0b", 0, 1'b0, 32'h0000_0008, 32'd0, 4'b0001, 32'hB000_0002, 1'b0);
        do_access("iso.rd2", 0, 1'b0, 32'h0020_0008, 32'd0, 4'b0100, 32'hAAAA_5555, 1'b0);
        chk("iso.mem1", mem[1][2], 32'hB000_0102);
        chk("iso.mem3", mem[3][2], 32'hB000_0302);

        // Back-to-back reads from r0 holding req across its ack
        drive(0, 1'b1, 1'b0, 32'h0010_0010, 32'd0);
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk($sformatf("b2b.r0_ack.c%0d", c), ifc.r0_ack, (c == 3 || c == 7));
            if (c == 5) chk("b2b.second_setup_sel", ifc.bus_bank_select, 4'b0010);
            if (c == 7) begin
                chk("b2b.rdata", ifc.r0_rdata, 32'h1234_5678);
                ifc.r0_req = 1'b0;
            end
        end
        tick();

        // Reset landing in the ACCESS cycle of a write
        drive(0, 1'b1, 1'b1, 32'h0030_0000, 32'h0F0F_0F0F);
        tick();
        tick();
        chk("rstacc.sel_before", ifc.bus_bank_select, 4'b1000);
        resetn = 1'b0;
        ifc.r0_req = 1'b0;
        #1;
        chk("rstacc.strobe", ifc.bus_write_strobe, 1'b0);
        tick();
        chk("rstacc.r0_ack", ifc.r0_ack, 1'b0);
        chk("rstacc.bus_address", ifc.bus_address, 32'd0);
        chk("rstacc.bus_wdata", ifc.bus_wdata, 32'd0);
        chk("rstacc.sel", ifc.bus_bank_select, 4'b0000);
        chk("rstacc.mem3", mem[3][0], 32'hB000_0300);
        resetn = 1'b1;
        tick();
        do_access("rstacc.r1", 1, 1'b0, 32'h0030_0000, 32'd0, 4'b1000, 32'hB000_0300, 1'b0);

        chk("bus_invariants", 64'(viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
